// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA raster generator and the
// sprite/ROM renderers that consume its outputs.
//   - *_DEF localparams : default 640x480@60 timing (25 MHz pixel clock)
//   - TILES_X/TILES_Y   : 16x16-pixel tile grid dimensions (40x30)
//   - pixel_coord_t     : raster coordinate type (DrawX/DrawY)
//   - tile_addr_t       : linear tile index type
//   - mul_const()       : constant multiply built from shifts and adds
//   - in_window()       : half-open range compare [lo, hi)
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF  = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_VISIBLE_DEF  = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int TILE_SHIFT_DEF = 4;
  localparam int FRAME_W_DEF    = 8;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int TILES_X     = H_VISIBLE_DEF >> TILE_SHIFT_DEF;
  localparam int TILES_Y     = V_VISIBLE_DEF >> TILE_SHIFT_DEF;
  localparam int TILE_ADDR_W = 11;

  typedef logic [9:0]             pixel_coord_t;
  typedef logic [TILE_ADDR_W-1:0] tile_addr_t;

  // Multiply by a constant using only shifts and adds; with a constant k the
  // loop unrolls into a fixed adder tree, so no multiplier is inferred.
  function automatic tile_addr_t mul_const(input tile_addr_t a, input int k);
    tile_addr_t acc;
    acc = '0;
    for (int b = 0; b < TILE_ADDR_W; b++) begin
      if (k[b]) acc = acc + (a << b);
    end
    return acc;
  endfunction

  function automatic logic in_window(input pixel_coord_t v,
                                     input pixel_coord_t lo,
                                     input pixel_coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator (640x480@60 by default) running on the pixel clock.
// All outputs are registered and describe the same raster position in the
// same cycle: every output is computed from the next counter value.
//
// Ports:
//   vga_clk     in   pixel clock, only clock
//   reset       in   synchronous, active-high
//   DrawX       out  current column, 0..H_TOTAL-1
//   DrawY       out  current row, 0..V_TOTAL-1
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low (whole lines)
//   blank       out  1 = active video, 0 = blanking
//   line_start  out  1-cycle pulse at DrawX==0
//   frame_start out  1-cycle pulse at DrawX==0, DrawY==0
//   tile_addr   out  (DrawX>>TILE_SHIFT) + (DrawY>>TILE_SHIFT)*tiles per line,
//                    forced to 0 during blanking
//   frame_count out  frames started since reset, wrapping
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int FRAME_W    = FRAME_W_DEF
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output pixel_coord_t           DrawX,
  output pixel_coord_t           DrawY,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [TILE_ADDR_W-1:0] tile_addr,
  output logic [FRAME_W-1:0]     frame_count
);

  localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int LINE_TILES = H_VISIBLE >> TILE_SHIFT;

  // Window bounds as 10-bit constants so every compare is width-matched.
  localparam pixel_coord_t H_LAST   = pixel_coord_t'(H_TOTAL - 1);
  localparam pixel_coord_t V_LAST   = pixel_coord_t'(V_TOTAL - 1);
  localparam pixel_coord_t H_ACTIVE = pixel_coord_t'(H_VISIBLE);
  localparam pixel_coord_t V_ACTIVE = pixel_coord_t'(V_VISIBLE);
  localparam pixel_coord_t HS_BEGIN = pixel_coord_t'(H_VISIBLE + H_FP);
  localparam pixel_coord_t HS_END   = pixel_coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam pixel_coord_t VS_BEGIN = pixel_coord_t'(V_VISIBLE + V_FP);
  localparam pixel_coord_t VS_END   = pixel_coord_t'(V_VISIBLE + V_FP + V_SYNC);

  pixel_coord_t x_nxt;
  pixel_coord_t y_nxt;
  pixel_coord_t col_idx;
  pixel_coord_t row_idx;
  logic         x_wrap;
  logic         active_nxt;
  logic         hs_nxt;
  logic         vs_nxt;
  logic         sol_nxt;
  logic         sof_nxt;
  tile_addr_t   tile_nxt;

  always_comb begin
    x_wrap     = 1'b0;
    x_nxt      = '0;
    y_nxt      = '0;
    col_idx    = '0;
    row_idx    = '0;
    active_nxt = 1'b0;
    hs_nxt     = 1'b1;
    vs_nxt     = 1'b1;
    sol_nxt    = 1'b0;
    sof_nxt    = 1'b0;
    tile_nxt   = '0;

    // ">=" rather than "==" so an out-of-range count (e.g. an upset) wraps
    // to 0 on the next edge instead of running up to 1023.
    x_wrap = (DrawX >= H_LAST);
    x_nxt  = x_wrap ? '0 : DrawX + 10'd1;

    if (x_wrap) begin
      y_nxt = (DrawY >= V_LAST) ? '0 : DrawY + 10'd1;
    end else begin
      y_nxt = (DrawY > V_LAST) ? '0 : DrawY;
    end

    active_nxt = (x_nxt < H_ACTIVE) && (y_nxt < V_ACTIVE);
    hs_nxt     = !in_window(x_nxt, HS_BEGIN, HS_END);
    vs_nxt     = !in_window(y_nxt, VS_BEGIN, VS_END);
    sol_nxt    = (x_nxt == '0);
    sof_nxt    = (x_nxt == '0) && (y_nxt == '0);

    col_idx = x_nxt >> TILE_SHIFT;
    row_idx = y_nxt >> TILE_SHIFT;
    if (active_nxt) begin
      tile_nxt = mul_const(tile_addr_t'(row_idx), LINE_TILES) + tile_addr_t'(col_idx);
    end
  end

  // Reset parks the raster on the last position of a frame, so the first
  // edge after release lands on (0,0) and the first frame is complete.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      tile_addr   <= '0;
      frame_count <= '1;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      blank       <= active_nxt;
      line_start  <= sol_nxt;
      frame_start <= sof_nxt;
      tile_addr   <= tile_nxt;
      if (sof_nxt) frame_count <= frame_count + FRAME_W'(1);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA raster timing on the pixel clock. Drives DrawX, DrawY and blank to every sprite/ROM renderer, and hs/vs to the DAC/connector. Also precomputes a registered 40x30 tile address, so renderers need no multiply/divide in their pixel path. Adds line/frame strobes and a frame counter for animation and turret state machines.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- TILE_SHIFT, 4, log2 of tile edge in pixels (16 px gives a 40x30 grid)
- FRAME_W, 8, frame_count width

Ports:
- vga_clk  in  1  pixel clock (25 MHz), the only clock
- reset  in  1  synchronous, active-high
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current row, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = active video (display enable), 0 = blanking
- line_start  out  1  1-cycle pulse when DrawX==0
- frame_start  out  1  1-cycle pulse when DrawX==0 and DrawY==0
- tile_addr  out  11  (DrawX>>TILE_SHIFT) + (DrawY>>TILE_SHIFT)*TILES_X; 0 when blank==0
- frame_count  out  FRAME_W  frames started since reset, modulo 2^FRAME_W

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = 525; TILES_X = H_VISIBLE>>TILE_SHIFT (40).
- Clock and reset: one clock domain. Reset is synchronous and active-high; it is sampled only on the vga_clk rising edge.
- All outputs are registers. Every output describes the same raster position in the same cycle, so the next-state logic computes each output from the next counter value.
- Reset state (held while reset=1):
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1
  - hs=1, vs=1, blank=0
  - line_start=0, frame_start=0, tile_addr=0
  - frame_count = all ones
- First edge with reset=0: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0. No pixel of the first frame is lost.
- Horizontal counter: increments every cycle. At H_TOTAL-1 it wraps to 0 and DrawY advances. DrawY wraps from V_TOTAL-1 to 0.
- frame_count increments on every transition into (0,0) and wraps naturally.
- Sync and blank windows:
  - hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751)
  - vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491); vs is level-based on the row, held for whole lines
  - blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE
- tile_addr arithmetic:
  - The multiply by TILES_X is done as shift/add, or with a registered row-base accumulator that adds TILES_X each time a tile row boundary is crossed.
  - Result is 11 bits; maximum value is 1199. No divider is permitted.
- Downstream ROMs are synchronous with 1 cycle of read latency. Renderers therefore register their own outputs; this block does not pre-skew for them.
- Reset asserted mid-frame: takes effect on the next edge, returning all outputs to the reset state. A new frame begins at (0,0) on the first edge after release.
- Counters never exceed TOTAL-1. Illegal values (e.g. after an SEU) wrap to 0 on the next edge.

Decomposition:
- Package vga_timing_pkg holds:
  - localparam defaults for the 640x480 timing, H_TOTAL, V_TOTAL
  - TILES_X=40, TILES_Y=30, TILE_ADDR_W=11
  - the typedef pixel_coord_t (logic [9:0])
- The sprite/ROM example modules import the same package.
- No sub-module. The two counters, window compares and tile accumulator form a single flat block.

Test Plan:
- Hold reset 3 cycles, then release -> during reset DrawX=799, DrawY=524, hs=vs=1, blank=0. First cycle after release: (0,0), blank=1, frame_start=1, frame_count=0.
- Run one line -> hs=0 exactly for DrawX 656..751 (96 cycles). blank falls at DrawX=640. line_start pulses once per 800 cycles.
- Run one frame -> vs=0 for DrawY 490..491 (1600 cycles). Count of blank=1 cycles per frame = 307200.
- Sample tile_addr:
  - (0,0) -> 0
  - (17,0) -> 1
  - (0,16) -> 40
  - (639,479) -> 1199
  - (640,0) -> 0 with blank=0
- Run across (799,524) three times -> next cycle is (0,0) with frame_start=1. frame_count steps 0->1->2->3. At FRAME_W=8, 256 frames wrap frame_count to 0.
- Assert reset at (300,200) for 1 cycle -> next cycle shows the reset state. On release the raster restarts at (0,0) with frame_count=0.
